// File: rtl/video_timing_gen.sv
// Runtime-programmable progressive video timing generator. Timing fields are shadowed
// in a pending set and move to the active set only at a frame boundary or while idle.
module video_timing_gen #(
   parameter int CNT_W     = 12,
   parameter int DEF_H_AV  = 640,
   parameter int DEF_H_FP  = 16,
   parameter int DEF_H_S   = 96,
   parameter int DEF_H_BP  = 48,
   parameter int DEF_V_AV  = 480,
   parameter int DEF_V_FP  = 10,
   parameter int DEF_V_S   = 2,
   parameter int DEF_V_BP  = 33,
   parameter int DEF_H_POL = 0,
   parameter int DEF_V_POL = 0
) (
   input  logic             PCLK_I,
   input  logic             SRst,
   input  logic             EN_I,
   input  logic [CNT_W-1:0] CFG_H_AV_I,
   input  logic [CNT_W-1:0] CFG_H_FP_I,
   input  logic [CNT_W-1:0] CFG_H_S_I,
   input  logic [CNT_W-1:0] CFG_H_BP_I,
   input  logic [CNT_W-1:0] CFG_V_AV_I,
   input  logic [CNT_W-1:0] CFG_V_FP_I,
   input  logic [CNT_W-1:0] CFG_V_S_I,
   input  logic [CNT_W-1:0] CFG_V_BP_I,
   input  logic             CFG_H_POL_I,
   input  logic             CFG_V_POL_I,
   input  logic             CFG_LOAD_I,
   output logic             CFG_BUSY_O,
   output logic [CNT_W-1:0] HCNT_O,
   output logic [CNT_W-1:0] VCNT_O,
   output logic             VDE_O,
   output logic             HS_O,
   output logic             VS_O,
   output logic             SOF_O,
   output logic             EOL_O
);

   localparam int TW     = CNT_W + 2;
   localparam int DEF_HT = DEF_H_AV + DEF_H_FP + DEF_H_S + DEF_H_BP;
   localparam int DEF_VT = DEF_V_AV + DEF_V_FP + DEF_V_S + DEF_V_BP;

   typedef struct packed {
      logic [CNT_W-1:0] h_av;
      logic [CNT_W-1:0] h_fp;
      logic [CNT_W-1:0] h_s;
      logic [CNT_W-1:0] h_bp;
      logic [CNT_W-1:0] v_av;
      logic [CNT_W-1:0] v_fp;
      logic [CNT_W-1:0] v_s;
      logic [CNT_W-1:0] v_bp;
      logic             h_pol;
      logic             v_pol;
   } timing_t;

   localparam timing_t DEF_TIMING = {
      CNT_W'(DEF_H_AV), CNT_W'(DEF_H_FP), CNT_W'(DEF_H_S), CNT_W'(DEF_H_BP),
      CNT_W'(DEF_V_AV), CNT_W'(DEF_V_FP), CNT_W'(DEF_V_S), CNT_W'(DEF_V_BP),
      1'(DEF_H_POL), 1'(DEF_V_POL)
   };

   function automatic logic [TW-1:0] h_total(input timing_t t);
      return TW'(t.h_av) + TW'(t.h_fp) + TW'(t.h_s) + TW'(t.h_bp);
   endfunction

   function automatic logic [TW-1:0] v_total(input timing_t t);
      return TW'(t.v_av) + TW'(t.v_fp) + TW'(t.v_s) + TW'(t.v_bp);
   endfunction

   timing_t          act;
   timing_t          pend;
   timing_t          cfg;
   timing_t          nxt;
   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] v;
   logic [TW-1:0]    ht;
   logic [TW-1:0]    vt;
   logic [TW-1:0]    nxt_ht;
   logic [TW-1:0]    nxt_vt;
   logic [TW-1:0]    hx;
   logic [TW-1:0]    vx;
   logic [TW-1:0]    hs_start;
   logic [TW-1:0]    hs_end;
   logic [TW-1:0]    vs_start;
   logic [TW-1:0]    vs_end;
   logic             h_last;
   logic             v_last;
   logic             frame_wrap;
   logic             apply;
   logic             hs_act;
   logic             vs_act;
   logic             vde_act;

   assign cfg = {CFG_H_AV_I, CFG_H_FP_I, CFG_H_S_I, CFG_H_BP_I,
                 CFG_V_AV_I, CFG_V_FP_I, CFG_V_S_I, CFG_V_BP_I,
                 CFG_H_POL_I, CFG_V_POL_I};

   // Position decode against the active set, plus the set that will be in force next cycle.
   always_comb begin
      ht         = h_total(act);
      vt         = v_total(act);
      hx         = TW'(h);
      vx         = TW'(v);
      h_last     = (hx == ht - TW'(1));
      v_last     = (vx == vt - TW'(1));
      frame_wrap = EN_I & h_last & v_last;
      apply      = CFG_BUSY_O & (frame_wrap | ~EN_I);
      if (apply) begin
         nxt = pend;
      end else begin
         nxt = act;
      end
      nxt_ht   = h_total(nxt);
      nxt_vt   = v_total(nxt);
      hs_start = TW'(act.h_av) + TW'(act.h_fp);
      hs_end   = hs_start + TW'(act.h_s);
      vs_start = TW'(act.v_av) + TW'(act.v_fp);
      vs_end   = vs_start + TW'(act.v_s);
      hs_act   = (hx >= hs_start) && (hx < hs_end);
      // VS toggles on the HS leading edge, so its first and last lines are partial.
      vs_act   = ((vx > vs_start) && (vx < vs_end)) ||
                 ((vx == vs_start) && (hx >= hs_start)) ||
                 ((vx == vs_end) && (hx < hs_start));
      vde_act  = (hx < TW'(act.h_av)) && (vx < TW'(act.v_av));
   end

   // Shadow register set: a load always wins the busy flag over a coincident apply.
   always_ff @(posedge PCLK_I) begin
      if (SRst) begin
         act        <= DEF_TIMING;
         pend       <= '0;
         CFG_BUSY_O <= 1'b0;
      end else begin
         if (apply) begin
            act <= pend;
         end
         if (CFG_LOAD_I) begin
            pend       <= cfg;
            CFG_BUSY_O <= 1'b1;
         end else if (apply) begin
            CFG_BUSY_O <= 1'b0;
         end
      end
   end

   // Pixel/line counters; idle parks them on the last pixel of the next-cycle timing.
   always_ff @(posedge PCLK_I) begin
      if (SRst) begin
         h <= CNT_W'(DEF_HT - 1);
         v <= CNT_W'(DEF_VT - 1);
      end else if (!EN_I) begin
         h <= CNT_W'(nxt_ht - TW'(1));
         v <= CNT_W'(nxt_vt - TW'(1));
      end else if (h_last) begin
         h <= {CNT_W{1'b0}};
         v <= v_last ? {CNT_W{1'b0}} : v + CNT_W'(1);
      end else begin
         h <= h + CNT_W'(1);
      end
   end

   // Output registers, all derived from the same counter snapshot.
   always_ff @(posedge PCLK_I) begin
      if (SRst) begin
         HCNT_O <= {CNT_W{1'b0}};
         VCNT_O <= {CNT_W{1'b0}};
         VDE_O  <= 1'b0;
         HS_O   <= ~DEF_TIMING.h_pol;
         VS_O   <= ~DEF_TIMING.v_pol;
         SOF_O  <= 1'b0;
         EOL_O  <= 1'b0;
      end else begin
         HCNT_O <= h;
         VCNT_O <= v;
         if (EN_I) begin
            VDE_O <= vde_act;
            HS_O  <= hs_act ~^ act.h_pol;
            VS_O  <= vs_act ~^ act.v_pol;
            SOF_O <= (h == {CNT_W{1'b0}}) && (v == {CNT_W{1'b0}});
            EOL_O <= h_last;
         end else begin
            VDE_O <= 1'b0;
            HS_O  <= ~act.h_pol;
            VS_O  <= ~act.v_pol;
            SOF_O <= 1'b0;
            EOL_O <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: a linear pixel-position model checked every cycle,
// plus hand-computed frame/line measurements on a full-size and a miniature instance.
module tb_video_timing_gen;

   typedef struct packed {
      int hav; int hfp; int hs; int hbp;
      int vav; int vfp; int vs; int vbp;
      bit hpol; bit vpol;
   } tim_t;

   typedef struct packed {
      tim_t act; tim_t pend; bit busy;
      int h; int v;
      bit vde; bit hs; bit vs; bit sof; bit eol;
      int hcnt; int vcnt;
   } mst_t;

   function automatic tim_t mk(input int hav, hfp, hs, hbp, vav, vfp, vs, vbp, input bit hpol, vpol);
      tim_t t;
      t.hav = hav; t.hfp = hfp; t.hs = hs; t.hbp = hbp;
      t.vav = vav; t.vfp = vfp; t.vs = vs; t.vbp = vbp;
      t.hpol = hpol; t.vpol = vpol;
      return t;
   endfunction

   function automatic int tot_h(input tim_t t);
      return t.hav + t.hfp + t.hs + t.hbp;
   endfunction

   function automatic int tot_v(input tim_t t);
      return t.vav + t.vfp + t.vs + t.vbp;
   endfunction

   // One clock of the reference: the frame is a single counter pos = v*HT + h.
   function automatic mst_t step(input mst_t s, input tim_t def, input bit rst, en, ld, input tim_t c);
      mst_t n;
      int ht, vt, pos, hss, vs0, vs1;
      bit hsa, vsa;
      n = s;
      if (rst) begin
         n.act = def; n.pend = '0; n.busy = 1'b0;
         n.h = tot_h(def) - 1; n.v = tot_v(def) - 1;
         n.vde = 1'b0; n.sof = 1'b0; n.eol = 1'b0; n.hcnt = 0; n.vcnt = 0;
         n.hs = !def.hpol; n.vs = !def.vpol;
         return n;
      end
      ht = tot_h(s.act);
      vt = tot_v(s.act);
      pos = s.v * ht + s.h;
      n.hcnt = s.h;
      n.vcnt = s.v;
      if (en) begin
         hss = s.act.hav + s.act.hfp;
         vs0 = (s.act.vav + s.act.vfp) * ht + hss;
         vs1 = (s.act.vav + s.act.vfp + s.act.vs) * ht + hss;
         hsa = (s.h >= hss) && (s.h < hss + s.act.hs);
         vsa = (pos >= vs0) && (pos < vs1);
         n.vde = (s.h < s.act.hav) && (s.v < s.act.vav);
         n.hs = s.act.hpol ? hsa : !hsa;
         n.vs = s.act.vpol ? vsa : !vsa;
         n.sof = (pos == 0);
         n.eol = (s.h == ht - 1);
         pos = (pos + 1) % (ht * vt);
         n.h = pos % ht;
         n.v = pos / ht;
         if (pos == 0 && s.busy) begin
            n.act = s.pend; n.busy = 1'b0;
         end
      end else begin
         n.vde = 1'b0; n.sof = 1'b0; n.eol = 1'b0;
         n.hs = !s.act.hpol; n.vs = !s.act.vpol;
         if (s.busy) begin
            n.act = s.pend; n.busy = 1'b0;
         end
         n.h = tot_h(n.act) - 1;
         n.v = tot_v(n.act) - 1;
      end
      if (ld) begin
         n.pend = c; n.busy = 1'b1;
      end
      return n;
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic srst, srst0, en, en0, load;
   tim_t cfg;
   int   nchk = 0;
   int   nerr = 0;
   bit   chk_on = 1'b0;
   bit   d0_done = 1'b0;

   logic        d0_busy, d0_vde, d0_hs, d0_vs, d0_sof, d0_eol;
   logic [11:0] d0_hcnt, d0_vcnt;
   logic        d1_busy, d1_vde, d1_hs, d1_vs, d1_sof, d1_eol;
   logic [11:0] d1_hcnt, d1_vcnt;

   video_timing_gen u_def (
      .PCLK_I(clk), .SRst(srst0), .EN_I(en0),
      .CFG_H_AV_I(12'd0), .CFG_H_FP_I(12'd0), .CFG_H_S_I(12'd0), .CFG_H_BP_I(12'd0),
      .CFG_V_AV_I(12'd0), .CFG_V_FP_I(12'd0), .CFG_V_S_I(12'd0), .CFG_V_BP_I(12'd0),
      .CFG_H_POL_I(1'b0), .CFG_V_POL_I(1'b0), .CFG_LOAD_I(1'b0),
      .CFG_BUSY_O(d0_busy), .HCNT_O(d0_hcnt), .VCNT_O(d0_vcnt), .VDE_O(d0_vde),
      .HS_O(d0_hs), .VS_O(d0_vs), .SOF_O(d0_sof), .EOL_O(d0_eol)
   );

   video_timing_gen #(
      .DEF_H_AV(8), .DEF_H_FP(2), .DEF_H_S(3), .DEF_H_BP(3),
      .DEF_V_AV(6), .DEF_V_FP(1), .DEF_V_S(2), .DEF_V_BP(2),
      .DEF_H_POL(0), .DEF_V_POL(0)
   ) u_dut (
      .PCLK_I(clk), .SRst(srst), .EN_I(en),
      .CFG_H_AV_I(cfg.hav[11:0]), .CFG_H_FP_I(cfg.hfp[11:0]),
      .CFG_H_S_I(cfg.hs[11:0]), .CFG_H_BP_I(cfg.hbp[11:0]),
      .CFG_V_AV_I(cfg.vav[11:0]), .CFG_V_FP_I(cfg.vfp[11:0]),
      .CFG_V_S_I(cfg.vs[11:0]), .CFG_V_BP_I(cfg.vbp[11:0]),
      .CFG_H_POL_I(cfg.hpol), .CFG_V_POL_I(cfg.vpol), .CFG_LOAD_I(load),
      .CFG_BUSY_O(d1_busy), .HCNT_O(d1_hcnt), .VCNT_O(d1_vcnt), .VDE_O(d1_vde),
      .HS_O(d1_hs), .VS_O(d1_vs), .SOF_O(d1_sof), .EOL_O(d1_eol)
   );

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   mst_t m0, m1;

   always @(posedge clk) begin
      m0 <= step(m0, mk(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0), srst0, en0, 1'b0, '0);
      m1 <= step(m1, mk(8, 2, 3, 3, 6, 1, 2, 2, 1'b0, 1'b0), srst, en, load, cfg);
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("d0_hcnt", int'(d0_hcnt), m0.hcnt);
         chk("d0_vcnt", int'(d0_vcnt), m0.vcnt);
         chk("d0_vde",  int'(d0_vde),  int'(m0.vde));
         chk("d0_hs",   int'(d0_hs),   int'(m0.hs));
         chk("d0_vs",   int'(d0_vs),   int'(m0.vs));
         chk("d0_sof",  int'(d0_sof),  int'(m0.sof));
         chk("d0_eol",  int'(d0_eol),  int'(m0.eol));
         chk("d0_busy", int'(d0_busy), int'(m0.busy));
         chk("d1_hcnt", int'(d1_hcnt), m1.hcnt);
         chk("d1_vcnt", int'(d1_vcnt), m1.vcnt);
         chk("d1_vde",  int'(d1_vde),  int'(m1.vde));
         chk("d1_hs",   int'(d1_hs),   int'(m1.hs));
         chk("d1_vs",   int'(d1_vs),   int'(m1.vs));
         chk("d1_sof",  int'(d1_sof),  int'(m1.sof));
         chk("d1_eol",  int'(d1_eol),  int'(m1.eol));
         chk("d1_busy", int'(d1_busy), int'(m1.busy));
      end
   end

   // Full-size 640x480 instance: line 0 shape and line period, hand-computed.
   initial begin
      int vde0, hs0, vslow, minh, maxh, prev, spacing;
      vde0 = 0; hs0 = 0; vslow = 0; minh = 100000; maxh = -1; prev = -1; spacing = 0;
      do @(negedge clk); while (srst0);
      for (int n = 0; n < 1700; n++) begin
         if (d0_vcnt == 12'd0) begin
            if (d0_vde) vde0++;
            if (!d0_hs) begin
               hs0++;
               if (int'(d0_hcnt) < minh) minh = int'(d0_hcnt);
               if (int'(d0_hcnt) > maxh) maxh = int'(d0_hcnt);
            end
         end
         if (!d0_vs) vslow++;
         if (d0_eol) begin
            if (prev >= 0) spacing = n - prev;
            prev = n;
         end
         @(negedge clk);
      end
      chk("def_vde_line0", vde0, 640);
      chk("def_hs_low_count", hs0, 96);
      chk("def_hs_first", minh, 656);
      chk("def_hs_last", maxh, 751);
      chk("def_no_vs_early", vslow, 0);
      chk("def_line_period", spacing, 800);
      d0_done = 1'b1;
   end

   task automatic wait_sof(input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!d1_sof && n < budget);
      if (!d1_sof) begin
         nchk++; nerr++;
         $display("FAIL wait_sof: no SOF within %0d cycles", budget);
      end
   endtask

   // Starts on an SOF cycle; returns cycles to the next SOF, HS-active clocks on line 0, VDE clocks.
   task automatic frame_stats(input bit pol, output int len, output int hs0, output int vde);
      len = 0; hs0 = 0; vde = 0;
      do begin
         if (d1_vcnt == 12'd0 && d1_hs == pol) hs0++;
         if (d1_vde) vde++;
         @(negedge clk);
         len++;
      end while (!d1_sof && len < 2000);
   endtask

   initial begin
      tim_t big, ma, mb, msm;
      int len, hs0, vde, n, bad;
      big = mk(12, 2, 2, 4, 5, 1, 1, 2, 1'b1, 1'b1);
      ma  = mk(4, 1, 1, 1, 3, 1, 1, 1, 1'b0, 1'b0);
      mb  = mk(6, 1, 2, 1, 4, 1, 1, 1, 1'b0, 1'b1);
      msm = mk(8, 2, 3, 3, 6, 1, 2, 2, 1'b0, 1'b0);
      srst = 1'b1; srst0 = 1'b1; en = 1'b1; en0 = 1'b1; load = 1'b0; cfg = '0;
      @(posedge clk);
      chk_on = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_vde", int'(d1_vde), 0);
      chk("rst_hs", int'(d1_hs), 1);
      chk("rst_vs", int'(d1_vs), 1);
      chk("rst_hcnt", int'(d1_hcnt), 0);
      chk("rst_busy", int'(d1_busy), 0);
      srst = 1'b0; srst0 = 1'b0;
      @(negedge clk);
      chk("edge1_sof", int'(d1_sof), 0);
      chk("edge1_eol", int'(d1_eol), 1);
      @(negedge clk);
      chk("edge2_sof", int'(d1_sof), 1);
      chk("edge2_vde", int'(d1_vde), 1);
      chk("edge2_hcnt", int'(d1_hcnt), 0);
      chk("edge2_sof_def", int'(d0_sof), 1);

      frame_stats(1'b0, len, hs0, vde);
      chk("def_frame_len", len, 176);
      chk("def_frame_hs", hs0, 3);
      chk("def_frame_vde", vde, 48);

      // mid-frame load of a larger, positive-sync mode
      repeat (50) @(negedge clk);
      cfg = big; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("load_busy_set", int'(d1_busy), 1);
      wait_sof(400, n);
      chk("load_old_frame_rest", n, 125);
      chk("load_busy_clear", int'(d1_busy), 0);
      frame_stats(1'b1, len, hs0, vde);
      chk("big_frame_len", len, 180);
      chk("big_frame_hs", hs0, 2);
      chk("big_frame_vde", vde, 60);

      // two loads in one frame: only the second takes effect
      repeat (30) @(negedge clk);
      cfg = ma; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (10) @(negedge clk);
      cfg = mb; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_sof(400, n);
      chk("two_load_old_rest", n, 138);
      frame_stats(1'b0, len, hs0, vde);
      chk("two_load_len", len, 70);
      chk("two_load_hs", hs0, 2);
      chk("two_load_vde", vde, 24);

      // pending set, then a second load exactly on the wrap cycle
      repeat (5) @(negedge clk);
      cfg = msm; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      n = 0;
      while (!(d1_hcnt == 12'd8 && d1_vcnt == 12'd6) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wrap_sync_found", int'(n < 200), 1);
      cfg = big; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("wrap_load_busy", int'(d1_busy), 1);
      chk("wrap_load_eol", int'(d1_eol), 1);
      wait_sof(5, n);
      frame_stats(1'b0, len, hs0, vde);
      chk("wrap_first_len", len, 176);
      chk("wrap_busy_clear", int'(d1_busy), 0);
      frame_stats(1'b1, len, hs0, vde);
      chk("wrap_second_len", len, 180);

      // idle for 100 clocks mid-frame, with a load applied while idle
      repeat (40) @(negedge clk);
      en = 1'b0; cfg = ma; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (d1_vde || d1_sof || d1_eol) bad++;
         if (i != 99) @(negedge clk);
      end
      chk("idle_quiet", bad, 0);
      chk("idle_hs_inactive", int'(d1_hs), 1);
      chk("idle_vs_inactive", int'(d1_vs), 1);
      chk("idle_busy_clear", int'(d1_busy), 0);
      en = 1'b1;
      @(negedge clk);
      chk("reen_edge1_sof", int'(d1_sof), 0);
      @(negedge clk);
      chk("reen_edge2_sof", int'(d1_sof), 1);
      chk("reen_edge2_vde", int'(d1_vde), 1);
      frame_stats(1'b0, len, hs0, vde);
      chk("reen_frame_len", len, 42);
      chk("reen_frame_hs", hs0, 1);
      chk("reen_frame_vde", vde, 12);

      // one-cycle reset mid-line with a pending set
      repeat (10) @(negedge clk);
      cfg = big; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      chk("mid_rst_vde", int'(d1_vde), 0);
      chk("mid_rst_sof", int'(d1_sof), 0);
      chk("mid_rst_eol", int'(d1_eol), 0);
      chk("mid_rst_hcnt", int'(d1_hcnt), 0);
      chk("mid_rst_vcnt", int'(d1_vcnt), 0);
      chk("mid_rst_hs", int'(d1_hs), 1);
      chk("mid_rst_vs", int'(d1_vs), 1);
      chk("mid_rst_busy", int'(d1_busy), 0);
      wait_sof(10, n);
      chk("mid_rst_sof_latency", n, 2);
      frame_stats(1'b0, len, hs0, vde);
      chk("mid_rst_frame_len", len, 176);
      chk("mid_rst_frame_vde", vde, 48);

      n = 0;
      while (!d0_done && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("def_monitor_done", int'(d0_done), 1);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Runtime-programmable video timing generator. It produces pixel-aligned HS/VS/VDE, pixel/line counters and frame/line markers for any progressive mode that fits in CNT_W-bit counters. It replaces fixed resolution-select tables with a shadowed timing register set that the control plane loads over a strobe and that takes effect only at a frame boundary. It sits in the pixel clock domain, between the mode-control logic and the pixel pipeline / TMDS encoder.

## Interface
- CNT_W, 12: width of all counters and timing fields.
- DEF_H_AV / DEF_H_FP / DEF_H_S / DEF_H_BP, 640/16/96/48: reset horizontal timing.
- DEF_V_AV / DEF_V_FP / DEF_V_S / DEF_V_BP, 480/10/2/33: reset vertical timing.
- DEF_H_POL / DEF_V_POL, 0/0: reset sync polarity. 0 = active-low, 1 = active-high.

Ports:
- PCLK_I  in  1  pixel clock; all logic sits on its rising edge.
- SRst  in  1  reset, synchronous, active-high.
- EN_I  in  1  run enable.
- CFG_H_AV_I, CFG_H_FP_I, CFG_H_S_I, CFG_H_BP_I  in  CNT_W each  requested horizontal field lengths (pixels).
- CFG_V_AV_I, CFG_V_FP_I, CFG_V_S_I, CFG_V_BP_I  in  CNT_W each  requested vertical field lengths (lines).
- CFG_H_POL_I, CFG_V_POL_I  in  1  requested polarities.
- CFG_LOAD_I  in  1  one-cycle strobe that captures all CFG_* inputs into the pending set.
- CFG_BUSY_O  out  1  high while a pending set is waiting to be applied.
- HCNT_O  out  CNT_W  pixel index; 0 = first active pixel.
- VCNT_O  out  CNT_W  line index; 0 = first active line.
- VDE_O  out  1  data enable.
- HS_O, VS_O  out  1  syncs at the programmed polarity.
- SOF_O  out  1  one-cycle pulse at pixel (0,0).
- EOL_O  out  1  one-cycle pulse at the last pixel of every line.

## Operation
- Totals: HT = H_AV+H_FP+H_S+H_BP and VT likewise, computed from the active set at CNT_W+2 bits.
- Legal configuration: every field ≥ 1 and HT, VT ≤ 2^CNT_W. Anything else is illegal, and the block's behaviour under it is undefined.
- Line layout: active, then front porch, then sync, then back porch.
- Internal counters h, v:
  - h wraps from HT-1 to 0.
  - v increments only on the h wrap, and wraps from VT-1 to 0.
- Outputs are registered and all reflect the same (h, v) of the previous cycle, so they are mutually aligned:
  - HCNT_O = h, VCNT_O = v.
  - VDE_O = (h < H_AV) and (v < V_AV).
  - HS active for H_AV+H_FP ≤ h < H_AV+H_FP+H_S.
  - VS active for lines V_AV+V_FP ≤ v < V_AV+V_FP+V_S. VS changes level only at h = H_AV+H_FP, i.e. it is co-timed with the HS leading edge.
  - SOF_O = (h=0 and v=0).
  - EOL_O = (h = HT-1).
- Config shadowing:
  - CFG_LOAD_I=1 copies all CFG_* inputs to the pending set and sets CFG_BUSY_O on the next edge.
  - On the internal wrap (h=HT-1 and v=VT-1, with EN_I=1), pending is copied to active and CFG_BUSY_O clears. The next frame runs fully on the new timing.
  - A second load while busy overwrites pending. Only the last load is applied.
  - A load on the same cycle as the wrap goes to pending and is applied at the following frame boundary. The boundary it coincides with applies the previous pending set, if any.
- EN_I=0: h and v are forced to HT-1 and VT-1 (idle), VDE_O=0, HS/VS inactive, SOF_O and EOL_O = 0. Pending config is applied immediately while idle. On EN_I rising, counting resumes from the idle position, so the first post-enable frame is complete.
- Reset (SRst=1):
  - Active set = DEF_* parameters; pending cleared; CFG_BUSY_O = 0.
  - h = HT-1, v = VT-1.
  - Output registers: VDE_O=0, SOF_O=0, EOL_O=0, HCNT_O=0, VCNT_O=0, HS_O and VS_O at inactive level (1 for POL=0).
- Reset mid-frame aborts the frame; there is no partial sync glitch beyond the reset cycle.

## Timing
- Counter-to-output latency: 1 PCLK.
- With EN_I=1, first edge after SRst falls: internal counters (0,0). Second edge: VDE_O=1, SOF_O=1, HCNT_O=0, VCNT_O=0.
- CFG_BUSY_O rises 1 cycle after the CFG_LOAD_I strobe and falls 1 cycle after the applying wrap.
- Polarity changes also take effect only at the frame boundary.
- Throughput: 1 pixel per clock, no stalls.

## Test plan
- Defaults, EN_I=1:
  - Line period 800 clocks.
  - VDE_O high for 640 consecutive clocks per line on lines 0–479, 0 on lines 480–524.
  - HS_O low for h 656–751.
  - VS_O low for lines 490–491, edges at h=656.
  - SOF_O every 420000 clocks.
- Load 1280x720 (1280/110/40/220, 720/5/5/20, POL 1/1) at mid-frame:
  - CFG_BUSY_O=1 until the wrap.
  - The current frame completes as 640x480.
  - Next frame has HT=1650 and VT=750, with HS high for h 1390–1429.
- Two loads in one frame (480x272 then 800x600): only 800x600 appears after the boundary.
- Load on the exact wrap cycle: the current boundary keeps the old timing, and the new timing appears one frame later.
- Toggle EN_I low for 100 clocks mid-frame:
  - Outputs idle throughout.
  - After re-enable, SOF_O on the 2nd edge, followed by a full 525-line frame.
- Assert SRst for 1 cycle mid-line with a pending config:
  - All outputs take their reset values.
  - Pending config is discarded; default timing resumes.
